// File: rtl/coreaxitoahbl_wbuf_writer.sv
// Fill-side controller for the 16-entry AXI-to-AHB-Lite write data buffer.
// Latency: a beat accepted at edge k is on wrEn/wrAddr/wrData/wrStrb from k; bufValid rises 3 edges after the final beat.
// Backpressure: WREADY is high only while filling; the filled buffer is held until bufRelease.
//
// Ports:
//   wrCLK, RESETN           clock, asynchronous active-low reset
//   burstStart, burstLen    burst announce pulse and AWLEN (beats = burstLen+1)
//   WVALID/WDATA/WSTRB/WLAST/WREADY  AXI W channel
//   wrEn, wrAddr, wrData, wrStrb     registered buffer write port
//   bufValid, beatCnt, burstBusy, lastErr  buffer status towards the drain side
//   bufRelease              drain side has consumed the buffer
module coreaxitoahbl_wbuf_writer #(
  parameter int AXI_DWIDTH    = 64,
  parameter int AXI_STRBWIDTH = AXI_DWIDTH / 8
) (
  input  logic                     wrCLK,
  input  logic                     RESETN,
  input  logic                     burstStart,
  input  logic [3:0]               burstLen,
  input  logic                     WVALID,
  input  logic [AXI_DWIDTH-1:0]    WDATA,
  input  logic [AXI_STRBWIDTH-1:0] WSTRB,
  input  logic                     WLAST,
  output logic                     WREADY,
  output logic                     wrEn,
  output logic [3:0]               wrAddr,
  output logic [AXI_DWIDTH-1:0]    wrData,
  output logic [AXI_STRBWIDTH-1:0] wrStrb,
  output logic                     bufValid,
  output logic [4:0]               beatCnt,
  output logic                     burstBusy,
  output logic                     lastErr,
  input  logic                     bufRelease
);

  typedef enum logic [1:0] {IDLE, FILL, SETTLE, FULL} state_t;

  state_t     state;
  logic [3:0] lenReg;
  logic [1:0] settleCnt;
  logic       wrHs;
  logic       finalBeat;

  // Both status flags are pure decodes of the state register.
  assign WREADY    = (state == FILL);
  assign burstBusy = (state != IDLE);

  assign wrHs      = WVALID & WREADY;
  // beatCnt never exceeds 15 while filling, so the low nibble is the beat index.
  assign finalBeat = (beatCnt[3:0] == lenReg);

  always_ff @(posedge wrCLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      lenReg    <= 4'd0;
      settleCnt <= 2'd0;
      wrEn      <= 1'b0;
      wrAddr    <= 4'd0;
      wrData    <= '0;
      wrStrb    <= '0;
      bufValid  <= 1'b0;
      beatCnt   <= 5'd0;
      lastErr   <= 1'b0;
    end else begin
      wrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (burstStart) begin
            lenReg  <= burstLen;
            beatCnt <= 5'd0;
            lastErr <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (wrHs) begin
            wrEn    <= 1'b1;
            wrAddr  <= beatCnt[3:0];
            wrData  <= WDATA;
            wrStrb  <= WSTRB;
            beatCnt <= beatCnt + 5'd1;
            // The count decides where the burst ends; WLAST is only audited.
            if (WLAST != finalBeat) lastErr <= 1'b1;
            if (finalBeat) begin
              state     <= SETTLE;
              settleCnt <= 2'd0;
            end
          end
        end
        SETTLE: begin
          // Wait out the buffer's input register and memory write edge so
          // every index reads back written data once bufValid is seen.
          if (settleCnt == 2'd2) begin
            state    <= FULL;
            bufValid <= 1'b1;
          end else begin
            settleCnt <= settleCnt + 2'd1;
          end
        end
        FULL: begin
          // A burstStart coinciding with the release is deliberately dropped.
          if (bufRelease) begin
            state    <= IDLE;
            bufValid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
